rvga_writeback: RTL

- Final pipeline stage of the rvga core; sits between the memory stage and the non-synthesising commit monitor.
- Holds one in-flight instruction and waits for the load response where needed.
- Forms the architectural rd value, writes the register file, and emits the commit debug word with its valid strobe.
- Keeps a retired-instruction counter.

---
 rtl/rvga_writeback.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/rvga_writeback.sv
// rvga writeback stage: one-entry holding register, load extraction, RF write and commit strobe.
// Ports: mem_* handshake in, ld_* load response, rf_w_* RF write, debug_word_* commit, instret_o, proto_err_o.
module rvga_writeback #(
  parameter int data_width_p = 32,
  parameter int instret_width_p = 64,
  localparam int cword_width_lp = 4 + 3 + 5 + 5 * data_width_p
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       mem_v_i,
  output logic                       mem_ready_o,
  input  logic [cword_width_lp-1:0]  mem_cword_i,
  input  logic                       ld_v_i,
  input  logic [data_width_p-1:0]    ld_data_i,
  output logic                       rf_w_v_o,
  output logic [4:0]                 rf_w_addr_o,
  output logic [data_width_p-1:0]    rf_w_data_o,
  output logic                       debug_word_v_o,
  output logic [cword_width_lp-1:0]  debug_word_o,
  output logic [instret_width_p-1:0] instret_o,
  output logic                       proto_err_o
);

  typedef enum logic [3:0] {
    e_rvga_opcode_lui   = 4'd0,
    e_rvga_opcode_auipc = 4'd1,
    e_rvga_opcode_jal   = 4'd2,
    e_rvga_opcode_jalr  = 4'd3,
    e_rvga_opcode_br    = 4'd4,
    e_rvga_opcode_ld    = 4'd5,
    e_rvga_opcode_st    = 4'd6,
    e_rvga_opcode_imm   = 4'd7,
    e_rvga_opcode_reg   = 4'd8,
    e_rvga_opcode_fence = 4'd9,
    e_rvga_opcode_misc  = 4'd10
  } rvga_opcode_e;

  typedef struct packed {
    rvga_opcode_e            opcode;
    logic [2:0]              funct3;
    logic [4:0]              rd;
    logic [data_width_p-1:0] pc;
    logic [data_width_p-1:0] imm;
    logic [data_width_p-1:0] alu_result;
    logic [data_width_p-1:0] rd_data;
    logic [data_width_p-1:0] ld_result;
  } rvga_writeback_cword;

  typedef enum logic {
    e_empty,
    e_full
  } state_e;

  state_e                     r_state;
  state_e                     w_state_n;
  rvga_writeback_cword        r_cw;
  rvga_writeback_cword        w_dbg;
  logic [instret_width_p-1:0] r_instret;
  logic                       r_err;

  logic                    w_full;
  logic                    w_is_ld;
  logic                    w_commit;
  logic                    w_accept;
  logic [1:0]              w_a;
  logic [7:0]              w_byte;
  logic [15:0]             w_half;
  logic [data_width_p-1:0] w_ld_val;
  logic                    w_ld_bad;
  logic [data_width_p-1:0] w_rd_val;
  logic                    w_wr;
  logic                    w_spur;

  assign w_full   = (r_state == e_full);
  assign w_is_ld  = (r_cw.opcode == e_rvga_opcode_ld);
  assign w_commit = w_full && (!w_is_ld || ld_v_i);
  assign mem_ready_o = !w_full || w_commit;
  assign w_accept = mem_v_i && mem_ready_o;

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      e_empty: if (w_accept) w_state_n = e_full;
      e_full:  if (w_commit && !w_accept) w_state_n = e_empty;
      default: w_state_n = e_empty;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= e_empty;
      r_cw    <= '0;
    end else begin
      r_state <= w_state_n;
      if (w_accept) begin
        r_cw           <= mem_cword_i;
        r_cw.rd_data   <= '0;
        r_cw.ld_result <= '0;
      end
    end
  end

  // Byte lane picked by the low address bits; halves by bit 1 only.
  assign w_a    = r_cw.alu_result[1:0];
  assign w_byte = ld_data_i[{w_a, 3'b000} +: 8];
  assign w_half = ld_data_i[{w_a[1], 4'b0000} +: 16];

  always_comb begin
    w_ld_val = '0;
    w_ld_bad = 1'b0;
    unique case (r_cw.funct3)
      3'b000: w_ld_val = {{(data_width_p-8){w_byte[7]}}, w_byte};
      3'b001: begin
        w_ld_val = {{(data_width_p-16){w_half[15]}}, w_half};
        w_ld_bad = w_a[0];
      end
      3'b010: begin
        w_ld_val = ld_data_i;
        w_ld_bad = (w_a != 2'b00);
      end
      3'b100: w_ld_val = {{(data_width_p-8){1'b0}}, w_byte};
      3'b101: begin
        w_ld_val = {{(data_width_p-16){1'b0}}, w_half};
        w_ld_bad = w_a[0];
      end
      default: w_ld_bad = 1'b1;
    endcase
  end

  always_comb begin
    w_rd_val = '0;
    w_wr     = 1'b0;
    unique case (r_cw.opcode)
      e_rvga_opcode_lui: begin
        w_rd_val = r_cw.imm;
        w_wr     = 1'b1;
      end
      e_rvga_opcode_auipc,
      e_rvga_opcode_imm,
      e_rvga_opcode_reg: begin
        w_rd_val = r_cw.alu_result;
        w_wr     = 1'b1;
      end
      e_rvga_opcode_jal,
      e_rvga_opcode_jalr: begin
        w_rd_val = r_cw.pc + data_width_p'(4);
        w_wr     = 1'b1;
      end
      e_rvga_opcode_ld: begin
        w_rd_val = w_ld_val;
        w_wr     = 1'b1;
      end
      default: begin
        w_rd_val = '0;
        w_wr     = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_dbg           = r_cw;
    w_dbg.rd_data   = (w_wr && r_cw.rd != 5'd0) ? w_rd_val : '0;
    w_dbg.ld_result = w_is_ld ? w_ld_val : '0;
  end

  assign rf_w_v_o       = w_commit && w_wr && (r_cw.rd != 5'd0);
  assign rf_w_addr_o    = r_cw.rd;
  assign rf_w_data_o    = w_rd_val;
  assign debug_word_v_o = w_commit;
  assign debug_word_o   = w_dbg;

  // A response is only legal while a load sits in the stage.
  assign w_spur = ld_v_i && !(w_full && w_is_ld);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_instret <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_commit) r_instret <= r_instret + 1'b1;
      if (w_spur || (w_commit && w_is_ld && w_ld_bad)) r_err <= 1'b1;
    end
  end

  assign instret_o   = r_instret;
  assign proto_err_o = r_err;

endmodule
